mux16_rr_arbiter: RTL and testbench

- Round-robin arbiter/controller that shares one 16:1 single-bit multiplexer among 16 requesters.
- Drives the mux 4-bit select, a one-hot grant vector and a valid flag qualifying the mux output.
- Enforces a bounded hold time per owner.
- Inserts one dead cycle between owners so the downstream consumer never sees a same-cycle source change.

---
 rtl/mux16_rr_arbiter.sv | 129 ++++++++++++
 tb/tb_mux16_rr_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mux16_rr_arbiter.sv
// Round-robin controller sharing one 16:1 single-bit mux among 16 requesters, with bounded hold and a dead cycle between owners.
// Optional macro ARB_LOCK_EN adds a lock input that suppresses the hold timeout while asserted.
module mux16_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
`ifdef ARB_LOCK_EN
  input  logic        lock,
`endif
  output logic [3:0]  sel,
  output logic [15:0] gnt,
  output logic        valid
);

  typedef enum logic [1:0] {IDLE, GRANT, SWITCH} state_t;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t            state_q, state_d;
  logic [3:0]        ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [15:0]       gnt_d;
  logic [3:0]        sel_d;
  logic              valid_d;

  logic              found;
  logic [3:0]        winner;
  logic              owner_req;
  logic              others;
  logic              lock_on;

`ifdef ARB_LOCK_EN
  assign lock_on = lock;
`else
  assign lock_on = 1'b0;
`endif

  // Scan ptr+1, ptr+2, ... with 4-bit wrap; i==16 lands on ptr itself, so the previous owner is checked last.
  always_comb begin
    found  = 1'b0;
    winner = ptr_q;
    for (int i = 1; i <= 16; i++) begin
      if (!found && req[ptr_q + 4'(i)]) begin
        found  = 1'b1;
        winner = ptr_q + 4'(i);
      end
    end
  end

  assign owner_req = req[ptr_q];
  assign others    = |(req & ~(16'b1 << ptr_q));

  // NOTE: every next-state signal gets a default first so this block can never infer a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    gnt_d   = gnt;
    sel_d   = sel;
    valid_d = valid;

    case (state_q)
      IDLE, SWITCH: begin
        hold_d = '0;
        if (found) begin
          state_d = GRANT;
          gnt_d   = 16'b1 << winner;
          sel_d   = winner;
          valid_d = 1'b1;
          ptr_d   = winner;
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
          valid_d = 1'b0;
        end
      end

      GRANT: begin
        if (!owner_req) begin
          state_d = SWITCH;
          gnt_d   = '0;
          valid_d = 1'b0;
          hold_d  = '0;
        end else if (lock_on) begin
          hold_d = '0;
        end else if (hold_q == HOLD_LAST) begin
          hold_d = '0;
          if (others) begin
            state_d = SWITCH;
            gnt_d   = '0;
            valid_d = 1'b0;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        valid_d = 1'b0;
        hold_d  = '0;
      end
    endcase
  end

  // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 4'd15;
      hold_q  <= '0;
      gnt     <= '0;
      sel     <= '0;
      valid   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt     <= gnt_d;
      sel     <= sel_d;
      valid   <= valid_d;
    end
  end

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Self-checking bench for mux16_rr_arbiter: directed scenarios plus randomized requests
// compared every cycle against an ownership-level reference model.
module tb_mux16_rr_arbiter;

  localparam int MAX_HOLD = 8;

  logic        clk;
  logic        rst_n;
  logic [15:0] req;
  logic        lock;
  logic [3:0]  sel;
  logic [15:0] gnt;
  logic        valid;

  int n_cmp;
  int n_err;

  // Reference model: who owns the mux, who owned it last, how long it has held it.
  int m_owner;
  int m_last;
  int m_sel;
  int m_held;

  mux16_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
`ifdef ARB_LOCK_EN
    .lock  (lock),
`endif
    .sel   (sel),
    .gnt   (gnt),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = 15;
    m_sel   = 0;
    m_held  = 0;
  endtask

  // One clock edge of the arbitration rules, applied to the request/lock values seen at that edge.
  task automatic model_step(input logic [15:0] r, input logic l);
    logic         others;
    logic         hit;
    int           c;
    if (m_owner >= 0) begin
      others = (r & ~(16'h1 << m_owner)) != 16'h0;
      if (!r[m_owner])              m_owner = -1;
      else if (l)                   m_held  = 1;
      else if (m_held == MAX_HOLD) begin
        if (others) m_owner = -1;
        else        m_held  = 1;
      end else                      m_held++;
    end else begin
      hit = 1'b0;
      for (int k = 1; k <= 16; k++) begin
        c = (m_last + k) % 16;
        if (!hit && r[c]) begin
          hit     = 1'b1;
          m_owner = c;
          m_last  = c;
          m_sel   = c;
          m_held  = 1;
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    logic [15:0] exp_gnt;
    exp_gnt = (m_owner >= 0) ? 16'(1 << m_owner) : 16'h0;
    check({tag, "_gnt"},    32'(gnt),   32'(exp_gnt));
    check({tag, "_sel"},    32'(sel),   32'(m_sel));
    check({tag, "_valid"},  32'(valid), 32'(m_owner >= 0));
    check({tag, "_onehot"}, 32'($countones(gnt) <= 1), 32'd1);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step(req, lock);
    #1;
    compare_all(tag);
  endtask

  task automatic mid_reset(input logic [15:0] req_after);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("async_rst");
    check("async_rst_gnt_zero", 32'(gnt), 32'h0);
    req = req_after;
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int run_len;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    req   = 16'hFFFF;
    lock  = 1'b0;
    model_reset();

    // Reset is asynchronous: outputs must be clear before any clock edge.
    #2;
    compare_all("reset");
    req = 16'h0;
    #5 rst_n = 1'b1;
    repeat (10) tick("idle");

    // Single requester 5.
    req = 16'h0020;
    tick("single");
    check("single_gnt_const", 32'(gnt), 32'h0020);
    check("single_sel_const", 32'(sel), 32'd5);
    repeat (4) tick("single");
    req = 16'h0;
    tick("single_drop");
    check("single_drop_valid", 32'(valid), 32'd0);
    tick("single_idle");

    // Two requesters at the extremes rotate with MAX_HOLD cycles each and a dead cycle.
    req = 16'h8001;
    repeat (40) tick("rotate");

    // A sole requester is never forced off.
    req = 16'h0;
    repeat (2) tick("pre_sole");
    req = 16'h0008;
    tick("sole");
    repeat (20) begin
      tick("sole");
      check("sole_valid_const", 32'(valid), 32'd1);
    end

    // Wrap order: 14 -> 15 -> 2.
    req = 16'h0;
    repeat (2) tick("pre_wrap");
    req = 16'h4000;
    repeat (2) tick("wrap14");
    req = 16'h8004;
    repeat (2) tick("wrap15");
    check("wrap15_sel_const", 32'(sel), 32'd15);
    req = 16'h0004;
    repeat (2) tick("wrap2");
    check("wrap2_sel_const", 32'(sel), 32'd2);

    // Async reset while owner 9 holds; search must restart at index 0.
    req = 16'h0;
    repeat (2) tick("pre_rst");
    req = 16'h0200;
    repeat (3) tick("owner9");
    mid_reset(16'h0201);
    tick("after_rst");
    check("after_rst_sel_const", 32'(sel), 32'd0);
    repeat (12) tick("after_rst");

`ifdef ARB_LOCK_EN
    req = 16'h0;
    repeat (2) tick("pre_lock");
    req = 16'h0008;
    repeat (2) tick("lock_owner3");
    lock = 1'b1;
    req  = 16'h0018;
    repeat (30) tick("lock_hold");
    check("lock_gnt_const", 32'(gnt), 32'h0008);
    lock = 1'b0;
    repeat (12) tick("lock_release");
    check("lock_rot_gnt_const", 32'(gnt), 32'h0010);
`endif

    // Randomized traffic, sparse and dense, with occasional mid-run resets.
    repeat (60) begin
      case ($urandom_range(0, 5))
        0:       req = 16'h0;
        1:       req = 16'hFFFF;
        2:       req = 16'(1 << $urandom_range(0, 15));
        default: req = 16'($urandom & $urandom);
      endcase
`ifdef ARB_LOCK_EN
      lock = ($urandom_range(0, 3) == 0);
`endif
      run_len = $urandom_range(1, 14);
      repeat (run_len) begin
        tick("rand");
        if ($urandom_range(0, 7) == 0) req = req ^ 16'(1 << $urandom_range(0, 15));
      end
      if ($urandom_range(0, 19) == 0) mid_reset(16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
